uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Transmit side of the matmul UART link: accepts one wide result bus (the packed output vector) through a valid/ready handshake.
- Splits the bus into BITS_PER_WORD words and sends each word as a fixed-length UART frame on tx, least-significant word first.
- Sits between the MVM output stage and the top-level tx pin; mirrors the bench-side UART receiver monitor.

Parameters:
- CLOCKS_PER_PULSE, 32, clock cycles per UART bit (>=1).
- BITS_PER_WORD, 8, data bits per frame.
- W_BUS, 16, parallel input width; must be a multiple of BITS_PER_WORD.
- PACKET_SIZE, 13, total bits per frame: start + data + stop/padding; must be >= BITS_PER_WORD+2.
- Derived N_WORDS = W_BUS/BITS_PER_WORD. Elaboration-time assertions on every constraint above.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- s_valid  in  1  input bus valid.
- s_ready  out  1  block idle and can accept a bus.
- s_data  in  W_BUS  parallel data; word i = s_data[i*BITS_PER_WORD +: BITS_PER_WORD].
- tx  out  1  UART serial line, idle high, registered.
- done  out  1  one-cycle pulse at end of last frame.

Behaviour:
- Reset (async, immediate): tx=1, s_ready=1, done=0. State IDLE; all counters 0; shift register cleared.
- FSM states:
  - IDLE: s_ready=1, tx=1.
  - SEND: s_ready=0.
- Handshake: s_valid && s_ready sampled at rising edge k.
  - At edge k: latch s_data into the shift register, enter SEND, s_ready=0, tx=0 (start bit).
  - s_data is sampled only at the handshake edge.
  - s_valid and s_data during SEND are ignored.
- Frame layout, bit index b = 0..PACKET_SIZE-1:
  - b=0: start bit, 0.
  - b=1..BITS_PER_WORD: data, LSB first.
  - b > BITS_PER_WORD: stop/padding, 1.
- Each bit is driven for exactly CLOCKS_PER_PULSE cycles.
  - Pulse counter 0..CLOCKS_PER_PULSE-1 wraps to 0 and advances the bit counter.
  - Bit counter wraps at PACKET_SIZE and advances the word counter.
- Frames are back-to-back with no idle cycles between words; the start bit of word i+1 follows the last padding bit of word i directly.
- Completion: the last padding bit of word N_WORDS-1 ends at edge k + N_WORDS*PACKET_SIZE*CLOCKS_PER_PULSE. At that edge:
  - state returns to IDLE, s_ready=1, tx=1, done=1 for one cycle.
- Back-to-back transfers: s_ready is high while IDLE. A handshake in the first IDLE cycle is accepted at the next edge, so the minimum gap between transfers is one idle-high cycle after the padding.
- CLOCKS_PER_PULSE=1: each bit lasts one cycle; counters must not underflow.
- Reset during SEND:
  - tx returns to 1 immediately; the frame is aborted.
  - No done pulse; latched data is discarded.
  - After rst deasserts, the block is IDLE with s_ready=1.
- done and s_ready never pulse or toggle without a preceding accepted handshake.

Test Plan:
- Reset: hold rst 3 cycles with s_valid=1 -> tx=1, s_ready=1, done=0 throughout; nothing accepted during reset.
- Single transfer (defaults), s_data=16'hA53C:
  - tx sequence 0,0,0,1,1,1,1,0,0,1,1,1,1 (0x3C), then 0,1,0,1,0,0,1,0,1,1,1,1,1 (0xA5), each level held 32 cycles.
  - s_ready low for exactly 832 cycles; done pulses once at edge k+832.
- Ignore during busy: hold s_valid=1 and change s_data to 16'h1234 at cycle 200 of a 16'hFFFF transfer:
  - transmitted words are 0xFF, 0xFF.
  - 16'h1234 is accepted only after s_ready rises and appears as 0x34, 0x12.
- Back-to-back: hold s_valid=1 with 16'h0000 then 16'hFFFF:
  - second start bit falls exactly one idle-high cycle after the first transfer's done pulse.
  - bench receiver (sample mid-bit, check padding==1) decodes 0x00, 0x00, 0xFF, 0xFF.
- Reset mid-frame: assert rst at cycle 100 of a transfer:
  - tx=1 in the same cycle (asynchronously), no done pulse.
  - After release, a new transfer of 16'h5AC3 decodes correctly as 0xC3, 0x5A.
- Parameter variant CLOCKS_PER_PULSE=1, W_BUS=24, PACKET_SIZE=10, s_data=24'h0180FF:
  - 30-cycle transfer decodes to 0xFF, 0x80, 0x01.
  - done pulses at edge k+30.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts one W_BUS-wide bus per handshake and sends it
// as N_WORDS back-to-back fixed-length frames, least-significant word first.
module uart_tx_serializer #(
    parameter int CLOCKS_PER_PULSE = 32,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_BUS            = 16,
    parameter int PACKET_SIZE      = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_BUS-1:0] s_data,
    output logic             tx,
    output logic             done
);
    localparam int N_WORDS = W_BUS / BITS_PER_WORD;
    localparam int PW      = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BW      = $clog2(PACKET_SIZE);
    localparam int WW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    localparam logic [PW-1:0] PULSE_LAST = PW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(PACKET_SIZE - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(BITS_PER_WORD);
    localparam logic [WW-1:0] WORD_LAST  = WW'(N_WORDS - 1);

    if (CLOCKS_PER_PULSE < 1) begin : g_chk_cpp
        $error("CLOCKS_PER_PULSE must be >= 1");
    end
    if (BITS_PER_WORD < 1 || (W_BUS % BITS_PER_WORD) != 0 || W_BUS < BITS_PER_WORD) begin : g_chk_bus
        $error("W_BUS must be a non-zero multiple of BITS_PER_WORD");
    end
    if (PACKET_SIZE < BITS_PER_WORD + 2) begin : g_chk_pkt
        $error("PACKET_SIZE must be >= BITS_PER_WORD + 2");
    end

    typedef enum logic {IDLE, SEND} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    pulse_q, pulse_d;
    logic [BW-1:0]    bit_q,   bit_d;
    logic [WW-1:0]    word_q,  word_d;
    logic [W_BUS-1:0] shreg_q, shreg_d;
    logic             tx_q,    tx_d;
    logic             done_q,  done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pulse_q <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // tx is computed one bit ahead so the line itself stays registered; data
    // bits are taken from shreg_q[0] and shifted out, which also lines up the
    // next word once a frame's data bits are consumed.
    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        bit_d   = bit_q;
        word_d  = word_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (s_valid) begin
                    state_d = SEND;
                    shreg_d = s_data;
                    tx_d    = 1'b0;
                    pulse_d = '0;
                    bit_d   = '0;
                    word_d  = '0;
                end
            end
            SEND: begin
                if (pulse_q != PULSE_LAST) begin
                    pulse_d = pulse_q + PW'(1);
                end else begin
                    pulse_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (word_q == WORD_LAST) begin
                            state_d = IDLE;
                            word_d  = '0;
                            tx_d    = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            word_d = word_q + WW'(1);
                            tx_d   = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                        if (bit_q < DATA_LAST) begin
                            tx_d    = shreg_q[0];
                            shreg_d = shreg_q >> 1;
                        end else begin
                            tx_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ready = (state_q == IDLE);
    assign tx      = tx_q;
    assign done    = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: default instance plus a CLOCKS_PER_PULSE=1,
// 24-bit, 10-bit-frame instance; outputs are logged every cycle and decoded afterwards.
module tb_uart_tx_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        va, ra, txa, dna;
    logic [15:0] da;
    logic        vb, rb, txb, dnb;
    logic [23:0] db;

    uart_tx_serializer dut_a (
        .clk(clk), .rst(rst), .s_valid(va), .s_ready(ra), .s_data(da), .tx(txa), .done(dna)
    );

    uart_tx_serializer #(
        .CLOCKS_PER_PULSE(1), .BITS_PER_WORD(8), .W_BUS(24), .PACKET_SIZE(10)
    ) dut_b (
        .clk(clk), .rst(rst), .s_valid(vb), .s_ready(rb), .s_data(db), .tx(txb), .done(dnb)
    );

    int vectors = 0;
    int miscompares = 0;
    int ecnt = 0;

    // entry n = outputs just after rising edge n
    logic lg_txa [8192];
    logic lg_rdya[8192];
    logic lg_dna [8192];
    logic lg_txb [8192];
    logic lg_rdyb[8192];
    logic lg_dnb [8192];

    always @(posedge clk) begin
        #1;
        if (ecnt < 8192) begin
            lg_txa[ecnt]  <= txa;
            lg_rdya[ecnt] <= ra;
            lg_dna[ecnt]  <= dna;
            lg_txb[ecnt]  <= txb;
            lg_rdyb[ecnt] <= rb;
            lg_dnb[ecnt]  <= dnb;
        end
        ecnt <= ecnt + 1;
    end

    // Mid-bit receiver over the log; bad counts start/padding framing errors.
    task automatic decode(input int sel, input int k, input int nw, input int cpp,
                          input int pkt, output logic [23:0] val, output int bad);
        int  idx;
        logic bt;
        val = '0;
        bad = 0;
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < pkt; b++) begin
                idx = k + (w * pkt + b) * cpp + cpp / 2;
                if (idx >= 0 && idx < 8192) bt = (sel != 0) ? lg_txb[idx] : lg_txa[idx];
                else bt = 1'bx;
                if (b == 0) begin
                    if (bt !== 1'b0) bad++;
                end else if (b <= 8) begin
                    val[w * 8 + b - 1] = bt;
                end else if (bt !== 1'b1) begin
                    bad++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; va = 1'b1; vb = 1'b1; da = 16'hFFFF; db = 24'hFFFFFF;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({txa, ra, dna, txb, rb, dnb} !== 6'b110110) begin
                miscompares++;
                $display("FAIL reset_hold: got tx/rdy/done a=%b%b%b b=%b%b%b want 110 110",
                         txa, ra, dna, txb, rb, dnb);
            end
        end
        va = 1'b0; vb = 1'b0; rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({txa, ra, dna, txb, rb, dnb} !== 6'b110110) begin
            miscompares++;
            $display("FAIL reset_release: got a=%b%b%b b=%b%b%b want 110 110",
                     txa, ra, dna, txb, rb, dnb);
        end
    endtask

    task automatic test_single();
        int k, cnt, first_bad;
        int exp_seq[26];
        exp_seq = '{0,0,0,1,1,1,1,0,0,1,1,1,1, 0,1,0,1,0,0,1,0,1,1,1,1,1};
        @(negedge clk);
        k = ecnt; va = 1'b1; da = 16'hA53C;
        @(negedge clk);
        va = 1'b0; da = 16'h0000;
        repeat (840) @(negedge clk);
        for (int j = 0; j < 26; j++) begin
            first_bad = -1;
            for (int c = 0; c < 32; c++)
                if (first_bad < 0 && lg_txa[k + j * 32 + c] !== exp_seq[j][0]) first_bad = c;
            vectors++;
            if (first_bad >= 0) begin
                miscompares++;
                $display("FAIL single_bit%0d: tx=%b at cycle %0d of bit, want %0d",
                         j, lg_txa[k + j * 32 + first_bad], first_bad, exp_seq[j]);
            end
        end
        cnt = 0;
        for (int i = k - 1; i <= k + 840; i++) if (lg_rdya[i] === 1'b0) cnt++;
        vectors++;
        if (cnt != 832 || lg_rdya[k + 831] !== 1'b0 || lg_rdya[k + 832] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready: low for %0d cycles (rdy@831=%b @832=%b), want 832 then high",
                     cnt, lg_rdya[k + 831], lg_rdya[k + 832]);
        end
        cnt = 0;
        for (int i = k - 1; i <= k + 840; i++) if (lg_dna[i] === 1'b1) cnt++;
        vectors++;
        if (cnt != 1 || lg_dna[k + 832] !== 1'b1 || lg_txa[k + 832] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_done: %0d pulses, done@k+832=%b tx=%b, want 1 pulse at k+832 with tx=1",
                     cnt, lg_dna[k + 832], lg_txa[k + 832]);
        end
    endtask

    task automatic test_ignore_busy();
        int k, k2, n, bad;
        logic [23:0] v;
        @(negedge clk);
        k = ecnt; va = 1'b1; da = 16'hFFFF;
        repeat (200) @(negedge clk);
        da = 16'h1234;
        n = 0;
        while (ra !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (ra !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_timeout: s_ready=%b after %0d cycles, want 1", ra, n);
            va = 1'b0;
            return;
        end
        k2 = ecnt;
        @(negedge clk);
        va = 1'b0;
        repeat (840) @(negedge clk);
        decode(0, k, 2, 32, 13, v, bad);
        vectors++;
        if (v[15:0] !== 16'hFFFF || bad != 0) begin
            miscompares++;
            $display("FAIL ignore_first: got %h (%0d framing errs), want ffff", v[15:0], bad);
        end
        decode(0, k2, 2, 32, 13, v, bad);
        vectors++;
        if (v[15:0] !== 16'h1234 || bad != 0) begin
            miscompares++;
            $display("FAIL ignore_second: got %h (%0d framing errs), want 1234", v[15:0], bad);
        end
        vectors++;
        if (k2 != k + 833) begin
            miscompares++;
            $display("FAIL ignore_accept_edge: accepted at k+%0d, want k+833", k2 - k);
        end
    endtask

    task automatic test_back_to_back();
        int k, k2, n, bad;
        logic [23:0] v;
        @(negedge clk);
        k = ecnt; va = 1'b1; da = 16'h0000;
        @(negedge clk);
        da = 16'hFFFF;
        n = 0;
        while (ra !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (ra !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_timeout: s_ready=%b after %0d cycles, want 1", ra, n);
            va = 1'b0;
            return;
        end
        k2 = ecnt;
        @(negedge clk);
        va = 1'b0;
        repeat (840) @(negedge clk);
        vectors++;
        if (k2 != k + 833 || lg_dna[k + 832] !== 1'b1 || lg_txa[k + 832] !== 1'b1
            || lg_txa[k + 833] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap: accept k+%0d done=%b idle_tx=%b start_tx=%b, want k+833 1 1 0",
                     k2 - k, lg_dna[k + 832], lg_txa[k + 832], lg_txa[k + 833]);
        end
        decode(0, k, 2, 32, 13, v, bad);
        vectors++;
        if (v[15:0] !== 16'h0000 || bad != 0) begin
            miscompares++;
            $display("FAIL b2b_first: got %h (%0d framing errs), want 0000", v[15:0], bad);
        end
        decode(0, k2, 2, 32, 13, v, bad);
        vectors++;
        if (v[15:0] !== 16'hFFFF || bad != 0) begin
            miscompares++;
            $display("FAIL b2b_second: got %h (%0d framing errs), want ffff", v[15:0], bad);
        end
    endtask

    task automatic test_reset_mid();
        int k, cnt, bad;
        logic [23:0] v;
        @(negedge clk);
        k = ecnt; va = 1'b1; da = 16'h0000;
        @(negedge clk);
        va = 1'b0;
        repeat (99) @(negedge clk);
        vectors++;
        if (txa !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_pre: tx=%b before reset, want 0", txa);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (txa !== 1'b1 || ra !== 1'b1 || dna !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_async: tx=%b rdy=%b done=%b, want 1 1 0", txa, ra, dna);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        cnt = 0;
        for (int i = k; i < ecnt; i++) if (lg_dna[i] === 1'b1) cnt++;
        vectors++;
        if (cnt != 0 || ra !== 1'b1 || txa !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_after: %0d done pulses rdy=%b tx=%b, want 0 1 1", cnt, ra, txa);
        end
        k = ecnt; va = 1'b1; da = 16'h5AC3;
        @(negedge clk);
        va = 1'b0;
        repeat (840) @(negedge clk);
        decode(0, k, 2, 32, 13, v, bad);
        vectors++;
        if (v[15:0] !== 16'h5AC3 || bad != 0 || lg_dna[k + 832] !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_resend: got %h (%0d framing errs) done=%b, want 5ac3 0 1",
                     v[15:0], bad, lg_dna[k + 832]);
        end
    endtask

    task automatic test_cpp1();
        int k, bad;
        logic [23:0] v;
        @(negedge clk);
        k = ecnt; vb = 1'b1; db = 24'h0180FF;
        @(negedge clk);
        vb = 1'b0;
        repeat (40) @(negedge clk);
        decode(1, k, 3, 1, 10, v, bad);
        vectors++;
        if (v !== 24'h0180FF || bad != 0) begin
            miscompares++;
            $display("FAIL cpp1_data: got %h (%0d framing errs), want 0180ff", v, bad);
        end
        vectors++;
        if (lg_dnb[k + 29] !== 1'b0 || lg_dnb[k + 30] !== 1'b1 || lg_dnb[k + 31] !== 1'b0
            || lg_rdyb[k + 29] !== 1'b0 || lg_rdyb[k + 30] !== 1'b1) begin
            miscompares++;
            $display("FAIL cpp1_done: done@29/30/31=%b%b%b rdy@29/30=%b%b, want 010 01",
                     lg_dnb[k + 29], lg_dnb[k + 30], lg_dnb[k + 31], lg_rdyb[k + 29], lg_rdyb[k + 30]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; va = 1'b0; vb = 1'b0; da = '0; db = '0;
        test_reset();
        test_single();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_cpp1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
